ray_prim_batch_issuer: RTL

Sequential front end for the combinational closest-hit/any-hit ray unit. Accepts one ray plus a BVH leaf primitive range, streams the AABB primitives from primitive memory into `WIDTH`-wide batches, and presents each batch to the ray unit. Captures the ray unit's per-batch result and reduces it across batches to a single closest hit, or to an early-exit any-hit result. Sits between BVH traversal (leaf requests) and the ray unit's `p[]`/`hit_data` interface.

---
 rtl/ray_prim_batch_issuer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ray_prim_batch_issuer.sv
// ray_prim_batch_issuer: streams leaf primitives into WIDTH-wide ray-unit batches and reduces hits; RAY_PRIM_ANY_HIT_EN enables any-hit early exit
`ifndef AABB_TEST_UNIT_SIZE
`define AABB_TEST_UNIT_SIZE 4
`endif
package ray_prim_pkg;
  typedef logic signed [31:0] Fixed;
  localparam Fixed FIXED_INF = 32'sh7fff_ffff;
  function automatic Fixed FixedInf();
    return FIXED_INF;
  endfunction
  typedef struct packed {
    Fixed ox, oy, oz, dx, dy, dz;
  } Ray;
  typedef struct packed {
    logic [15:0] idx;
    Fixed min_x, min_y, min_z, max_x, max_y, max_z;
  } BVH_Primitive_AABB;
  typedef struct packed {
    logic bHit;
    Fixed T;
    logic [15:0] PI;
  } HitData;
endpackage

module ray_prim_batch_issuer
  import ray_prim_pkg::*;
#(
  parameter int WIDTH = `AABB_TEST_UNIT_SIZE,
  parameter int IDX_W = 16,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  Ray req_ray,
  input  logic [IDX_W-1:0] req_start,
  input  logic [CNT_W-1:0] req_count,
  input  logic req_any,
  output logic mem_rd_en,
  output logic [IDX_W-1:0] mem_rd_addr,
  input  BVH_Primitive_AABB mem_rd_data,
  output Ray unit_ray,
  output BVH_Primitive_AABB [WIDTH-1:0] unit_p,
  input  HitData unit_hit,
  output logic res_valid,
  input  logic res_ready,
  output HitData res_hit,
  output logic res_any_hit
);
  localparam int SW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam HitData NO_HIT = '{bHit: 1'b0, T: FIXED_INF, PI: '0};
  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] base;
  logic [CNT_W-1:0] remaining, k, n;
  logic cap;
  logic [SW-1:0] cap_slot;
  logic early;
  HitData best;
  assign n = remaining < CNT_W'(WIDTH) ? remaining : CNT_W'(WIDTH);
`ifdef RAY_PRIM_ANY_HIT_EN
  logic any;
  assign early = any & unit_hit.bHit;
  always_ff @(posedge clk)
    if (reset) any <= 1'b0;
    else if (state == IDLE && req_valid) any <= req_any;
`else
  logic unused_any;
  assign unused_any = req_any;
  assign early = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (req_count == '0 ? DONE : FETCH) : IDLE;
      FETCH:   state_nx = k == n ? EVAL : FETCH;
      EVAL:    state_nx = (remaining == n || early) ? DONE : FETCH;
      default: state_nx = res_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    req_ready = !reset && state == IDLE;
    mem_rd_en = !reset && state == FETCH && k < n;
    mem_rd_addr = base + IDX_W'(k);
    res_valid = !reset && state == DONE;
    res_any_hit = res_valid && best.bHit;
    res_hit = best;
  end
  // Read k returns one cycle later; pad unused slots with slot 0 once the last read lands.
  always_ff @(posedge clk)
    if (reset) begin
      base <= '0;
      remaining <= '0;
      k <= '0;
      cap <= 1'b0;
      cap_slot <= '0;
      best <= NO_HIT;
      unit_ray <= '0;
      unit_p <= '0;
    end else begin
      cap <= mem_rd_en;
      cap_slot <= k[SW-1:0];
      if (cap) unit_p[cap_slot] <= mem_rd_data;
      case (state)
        IDLE: if (req_valid) begin
          unit_ray <= req_ray;
          base <= req_start;
          remaining <= req_count;
          best <= NO_HIT;
          k <= '0;
        end
        FETCH: begin
          k <= k + 1'b1;
          if (k == n)
            for (int j = 0; j < WIDTH; j++)
              if (CNT_W'(j) >= n) unit_p[j] <= n == CNT_W'(1) ? mem_rd_data : unit_p[0];
        end
        EVAL: begin
          if (unit_hit.bHit && unit_hit.T < best.T) best <= unit_hit;
          base <= base + IDX_W'(n);
          remaining <= remaining - n;
          k <= '0;
        end
        default: ;
      endcase
    end
endmodule
